// File: rtl/replicator_broadcast_if.sv
// Handshake bundle for the replicator broadcast scheduler.
//   upstream : in_valid / in_ready / in_data / lane_mask
//   lanes    : out_valid / out_ready / out_data (lane k at out_data[k*2**WIRE +: 2**WIRE])
// master = upstream source plus lane sinks; slave = the scheduler.
interface replicator_broadcast_if #(
  parameter int WIRE = 3,
  parameter int WAY  = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [2**WIRE-1:0]            in_data;
  logic [2**WAY-1:0]             lane_mask;
  logic [2**WAY-1:0]             out_valid;
  logic [2**WAY-1:0]             out_ready;
  logic [2**WAY*2**WIRE-1:0]     out_data;

  modport master (
    output in_valid, in_data, lane_mask, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, lane_mask, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/replicator_broadcast_ctrl.sv
// Broadcast scheduler: takes one word upstream and offers it to a masked
// subset of lanes, holding it until every selected lane has handshaked.
// Lanes still pending after TIMEOUT cycles are dropped and reported.
// Ports:
//   clk, rst            clock, async active-high reset
//   bus (slave)         upstream + per-lane handshakes (see replicator_broadcast_if)
//   busy                1 while a word is being held
//   bcast_done          1-cycle pulse, word delivered or discarded (empty mask)
//   err_timeout         1-cycle pulse, pending lanes dropped
//   err_lanes           lanes dropped at the last timeout, held until the next one
//   bcast_count         completed broadcasts, wrapping

// One lane's pending flag; it doubles as that lane's out_valid.
module replicator_lane (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic kill,
  input  logic ready,
  output logic valid
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid <= 1'b0;
    else if (load) valid <= load_val;
    else if (kill) valid <= 1'b0;
    else if (ready) valid <= 1'b0;
  end
endmodule

module replicator_broadcast_ctrl #(
  parameter int WIRE    = 3,
  parameter int WAY     = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  replicator_broadcast_if.slave  bus,
  output logic                   busy,
  output logic                   bcast_done,
  output logic                   err_timeout,
  output logic [2**WAY-1:0]      err_lanes,
  output logic [CNT_W-1:0]       bcast_count
);
  localparam int W    = 2**WIRE;
  localparam int L    = 2**WAY;
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [W-1:0]    data;
  logic [TW-1:0]   timer;
  logic [L-1:0]    pend;
  logic [L-1:0]    rem;
  logic            hold, complete, tmo, rdy, accept, zero_mask;

  assign hold      = (state == HOLD);
  assign rem       = pend & ~bus.out_ready;
  assign complete  = hold && (rem == '0);
  // Completion is checked first through rem == 0, so it wins over timeout.
  assign tmo       = (TIMEOUT > 0) && hold && (rem != '0) && (timer == TMAX[TW-1:0]);
  assign rdy       = !rst && !tmo && (!hold || (rem == '0));
  assign accept    = bus.in_valid && rdy;
  assign zero_mask = (bus.lane_mask == '0);

  assign bus.in_ready  = rdy;
  assign bus.out_valid = pend;

  genvar k;
  generate
    for (k = 0; k < L; k++) begin : g_lane
      replicator_lane u_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (bus.lane_mask[k]),
        .kill     (tmo),
        .ready    (bus.out_ready[k]),
        .valid    (pend[k])
      );
      assign bus.out_data[k*W +: W] = data;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      data        <= '0;
      timer       <= '0;
      bcast_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_lanes   <= '0;
      bcast_count <= '0;
    end else begin
      bcast_done  <= complete || (accept && zero_mask);
      err_timeout <= tmo;
      // An empty-mask word accepted on the completing edge finishes too,
      // so both completions are counted.
      bcast_count <= bcast_count + CNT_W'(complete) + CNT_W'(accept && zero_mask);
      if (accept) begin
        data  <= bus.in_data;
        timer <= '0;
        state <= zero_mask ? IDLE : HOLD;
        busy  <= !zero_mask;
      end else if (complete || tmo) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (tmo) err_lanes <= rem;
      end else if (hold) begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule
